pulse_train_generator: RTL and testbench

Transmit-side counterpart to the edge/pulse detectors in the sequential-basics block set. On an accepted start request it emits a train of N high pulses on a single line, each H cycles wide and separated by L-cycle low gaps, then signals completion. With H=1 and L>=1 every pulse is a clean 0-1-0 pattern, so a one-cycle pulse detector on the receiving end sees exactly N detections.

---
 rtl/pulse_train_generator.sv | 159 +++++++++++++++
 tb/tb_pulse_train_generator.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pulse_train_generator.sv
// pulse_train_generator
//
// On an accepted start request, emits N high pulses on pulse_out, each H
// cycles wide and separated by L-cycle low gaps, then raises done for one
// cycle and returns to idle. H=0 and L=0 are treated as 1, so pulses are
// always separated by at least one low cycle. N=0 goes straight to DONE.
//
// Optional feature: define PULSE_TRAIN_GEN_ABORT_EN to add the abort input,
// which ends a train in progress (HIGH or LOW) through DONE.
//
// Handshake: a request is accepted on a rising clk edge where
// start_valid && start_ready; num_pulses/high_len/low_len are captured on
// that edge and ignored otherwise. start_ready depends on state only.
//
// Ports:
//   clk          clock, all logic on posedge
//   rst          synchronous active-high reset
//   start_valid  start request
//   start_ready  idle, request can be accepted
//   num_pulses   N, pulse count
//   high_len     H, high-phase length in cycles
//   low_len      L, gap length in cycles
//   abort        (PULSE_TRAIN_GEN_ABORT_EN only) terminate the current train
//   pulse_out    generated pulse line
//   busy         train in progress (HIGH or LOW)
//   done         one-cycle completion strobe
//   pulses_left  HIGH phases not yet completed

module pulse_train_generator #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    input  logic [CNT_W-1:0] num_pulses,
    input  logic [CNT_W-1:0] high_len,
    input  logic [CNT_W-1:0] low_len,
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    input  logic             abort,
`endif
    output logic             pulse_out,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] pulses_left
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state_q, state_d;
    // Phase counter holds the remaining cycles of the current phase minus one,
    // so a phase ends when it reads zero and no value ever wraps.
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] high_m1_q, high_m1_d;
    logic [CNT_W-1:0] low_m1_q, low_m1_d;
    logic [CNT_W-1:0] left_q, left_d;
    logic             abort_req;

`ifdef PULSE_TRAIN_GEN_ABORT_EN
    assign abort_req = abort;
`else
    assign abort_req = 1'b0;
`endif

    // Phase length minus one, with a zero length treated as one cycle.
    function automatic logic [CNT_W-1:0] len_m1(input logic [CNT_W-1:0] len);
        return (len == '0) ? '0 : (len - ONE);
    endfunction

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        high_m1_d = high_m1_q;
        low_m1_d  = low_m1_q;
        left_d    = left_q;
        case (state_q)
            IDLE: begin
                if (start_valid) begin
                    high_m1_d = len_m1(high_len);
                    low_m1_d  = len_m1(low_len);
                    cnt_d     = len_m1(high_len);
                    left_d    = num_pulses;
                    state_d   = (num_pulses == '0) ? DONE : HIGH;
                end
            end
            HIGH: begin
                if (abort_req) begin
                    state_d = DONE;
                    left_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    left_d = left_q - ONE;
                    if (left_q == ONE) begin
                        state_d = DONE;
                    end else begin
                        state_d = LOW;
                        cnt_d   = low_m1_q;
                    end
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            LOW: begin
                if (abort_req) begin
                    state_d = DONE;
                    left_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = high_m1_q;
                end else begin
                    cnt_d = cnt_q - ONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they change together
    // with the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            high_m1_q   <= '0;
            low_m1_q    <= '0;
            left_q      <= '0;
            pulse_out   <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            start_ready <= 1'b1;
            pulses_left <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            high_m1_q   <= high_m1_d;
            low_m1_q    <= low_m1_d;
            left_q      <= left_d;
            pulse_out   <= (state_d == HIGH);
            busy        <= (state_d == HIGH) || (state_d == LOW);
            done        <= (state_d == DONE);
            start_ready <= (state_d == IDLE);
            pulses_left <= left_d;
        end
    end

endmodule

// File: tb/tb_pulse_train_generator.sv
module tb_pulse_train_generator;

    localparam int CNT_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start_valid = 1'b0;
    logic             start_ready;
    logic [CNT_W-1:0] num_pulses = '0;
    logic [CNT_W-1:0] high_len = '0;
    logic [CNT_W-1:0] low_len = '0;
`ifdef PULSE_TRAIN_GEN_ABORT_EN
    logic             abort = 1'b0;
`endif
    logic             pulse_out;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] pulses_left;

    int checks = 0;
    int errors = 0;

    pulse_train_generator #(.CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start_valid (start_valid),
        .start_ready (start_ready),
        .num_pulses  (num_pulses),
        .high_len    (high_len),
        .low_len     (low_len),
`ifdef PULSE_TRAIN_GEN_ABORT_EN
        .abort       (abort),
`endif
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done),
        .pulses_left (pulses_left)
    );

    // Clock / reset
    always #5 clk = ~clk;

    // Driver: present a request before an edge; that edge is E0. Returns
    // right after E0, so the next negedge is cycle 1.
    task automatic drive_start(input int n, input int h, input int l);
        @(negedge clk);
        num_pulses  = CNT_W'(n);
        high_len    = CNT_W'(h);
        low_len     = CNT_W'(l);
        start_valid = 1'b1;
        @(posedge clk);
    endtask

    // Status nibble sampled per cycle: {pulse_out, busy, done, start_ready}
    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({pulse_out, busy, done, start_ready} !== 4'b0001 || pulses_left !== 8'd0) begin
            errors++;
            $display("FAIL reset_hold: status=%b left=%0d, required status=0001 left=0",
                     {pulse_out, busy, done, start_ready}, pulses_left);
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if ({pulse_out, busy, done, start_ready} !== 4'b0001 || pulses_left !== 8'd0) begin
            errors++;
            $display("FAIL reset_release: status=%b left=%0d, required status=0001 left=0",
                     {pulse_out, busy, done, start_ready}, pulses_left);
        end
    endtask

    // N=3,H=1,L=2; inputs scrambled after acceptance; count 010 patterns
    task automatic test_basic();
        logic [3:0] e [1:9] = '{4'b1100, 4'b0100, 4'b0100, 4'b1100, 4'b0100,
                                4'b0100, 4'b1100, 4'b0010, 4'b0001};
        int el [1:9] = '{3, 2, 2, 2, 1, 1, 1, 0, 0};
        logic p2, p1;
        int hits;
        p2 = 1'b0; p1 = 1'b0; hits = 0;
        drive_start(3, 1, 2);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            checks++;
            if ({pulse_out, busy, done, start_ready} !== e[k] || pulses_left !== CNT_W'(el[k])) begin
                errors++;
                $display("FAIL basic cycle %0d: status=%b left=%0d, required status=%b left=%0d",
                         k, {pulse_out, busy, done, start_ready}, pulses_left, e[k], el[k]);
            end
            if (!p2 && p1 && !pulse_out) hits++;
            p2 = p1; p1 = pulse_out;
            if (k == 1) begin
                start_valid = 1'b0;
                num_pulses = 8'd9; high_len = 8'd7; low_len = 8'd0;
            end
        end
        checks++;
        if (hits != 3) begin
            errors++;
            $display("FAIL basic_detector: hits=%0d, required 3", hits);
        end
    endtask

    // H=0,L=0 behave as 1
    task automatic test_zero_len();
        logic [3:0] e [1:5] = '{4'b1100, 4'b0100, 4'b1100, 4'b0010, 4'b0001};
        int el [1:5] = '{2, 1, 1, 0, 0};
        drive_start(2, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk);
            checks++;
            if ({pulse_out, busy, done, start_ready} !== e[k] || pulses_left !== CNT_W'(el[k])) begin
                errors++;
                $display("FAIL zero_len cycle %0d: status=%b left=%0d, required status=%b left=%0d",
                         k, {pulse_out, busy, done, start_ready}, pulses_left, e[k], el[k]);
            end
            if (k == 1) start_valid = 1'b0;
        end
    endtask

    // N=0 goes straight to DONE
    task automatic test_zero_count();
        logic [3:0] e [1:3] = '{4'b0010, 4'b0001, 4'b0001};
        drive_start(0, 5, 5);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            checks++;
            if ({pulse_out, busy, done, start_ready} !== e[k] || pulses_left !== 8'd0) begin
                errors++;
                $display("FAIL zero_count cycle %0d: status=%b left=%0d, required status=%b left=0",
                         k, {pulse_out, busy, done, start_ready}, pulses_left, e[k]);
            end
            if (k == 1) start_valid = 1'b0;
        end
    endtask

    // start_valid held: re-accept on the first IDLE cycle
    task automatic test_back_to_back();
        logic [3:0] e [1:10] = '{4'b1100, 4'b1100, 4'b1100, 4'b0010, 4'b0001,
                                 4'b1100, 4'b1100, 4'b1100, 4'b0010, 4'b0001};
        int el [1:10] = '{1, 1, 1, 0, 0, 1, 1, 1, 0, 0};
        drive_start(1, 3, 1);
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            checks++;
            if ({pulse_out, busy, done, start_ready} !== e[k] || pulses_left !== CNT_W'(el[k])) begin
                errors++;
                $display("FAIL back_to_back cycle %0d: status=%b left=%0d, required status=%b left=%0d",
                         k, {pulse_out, busy, done, start_ready}, pulses_left, e[k], el[k]);
            end
            if (k == 6) start_valid = 1'b0;
        end
    endtask

    // Reset asserted during cycle 3 of a long train
    task automatic test_mid_reset();
        logic [3:0] e [1:8] = '{4'b1100, 4'b1100, 4'b1100, 4'b0001,
                                4'b0001, 4'b0001, 4'b0001, 4'b0001};
        int el [1:8] = '{5, 5, 5, 0, 0, 0, 0, 0};
        drive_start(5, 4, 4);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if ({pulse_out, busy, done, start_ready} !== e[k] || pulses_left !== CNT_W'(el[k])) begin
                errors++;
                $display("FAIL mid_reset cycle %0d: status=%b left=%0d, required status=%b left=%0d",
                         k, {pulse_out, busy, done, start_ready}, pulses_left, e[k], el[k]);
            end
            if (k == 1) start_valid = 1'b0;
            if (k == 3) rst = 1'b1;
            if (k == 4) rst = 1'b0;
        end
    endtask

    // Large lengths/counts: high cycles, rising edges, done cycle
    task automatic test_max(input int n, input int h, input int l);
        int highs, rises, done_at, exp_done;
        logic prev;
        highs = 0; rises = 0; done_at = -1; prev = 1'b0;
        exp_done = n * h + (n - 1) * l + 1;
        drive_start(n, h, l);
        for (int k = 1; k <= 3000 && done_at < 0; k++) begin
            @(negedge clk);
            if (k == 1) start_valid = 1'b0;
            if (pulse_out) highs++;
            if (pulse_out && !prev) rises++;
            prev = pulse_out;
            if (done) done_at = k;
        end
        checks++;
        if (done_at != exp_done || highs != n * h || rises != n) begin
            errors++;
            $display("FAIL max n=%0d h=%0d l=%0d: done_at=%0d highs=%0d rises=%0d, required %0d %0d %0d",
                     n, h, l, done_at, highs, rises, exp_done, n * h, n);
        end
        @(negedge clk);
        checks++;
        if (start_ready !== 1'b1) begin
            errors++;
            $display("FAIL max_ready: start_ready=%b, required 1", start_ready);
        end
    endtask

`ifdef PULSE_TRAIN_GEN_ABORT_EN
    // abort during cycle 2 (HIGH phase end coincides; abort wins)
    task automatic test_abort();
        logic [3:0] e [1:8] = '{4'b1100, 4'b1100, 4'b0010, 4'b0001,
                                4'b0001, 4'b0001, 4'b0001, 4'b0001};
        int el [1:8] = '{4, 4, 0, 0, 0, 0, 0, 0};
        drive_start(4, 2, 2);
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            checks++;
            if ({pulse_out, busy, done, start_ready} !== e[k] || pulses_left !== CNT_W'(el[k])) begin
                errors++;
                $display("FAIL abort cycle %0d: status=%b left=%0d, required status=%b left=%0d",
                         k, {pulse_out, busy, done, start_ready}, pulses_left, e[k], el[k]);
            end
            if (k == 1) start_valid = 1'b0;
            if (k == 2) abort = 1'b1;
            if (k == 3) abort = 1'b0;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_zero_count();
        test_back_to_back();
        test_mid_reset();
        test_max(2, 255, 255);
        test_max(255, 1, 1);
`ifdef PULSE_TRAIN_GEN_ABORT_EN
        test_abort();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
